vblank_update_scheduler: RTL and testbench
==========================================

Name: vblank_update_scheduler

Overview:
- Sequences game-logic updaters so they only touch shared frame state during vertical blanking.
- Watches hpos/vpos from hvsync_generator and opens an update window once per frame.
- Grants the window one requester at a time with a req/grant/done handshake.
- Sits between hvsync_generator and the game-object modules (paddles, ball, score).

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- OPEN_LINE, 480, vpos at which the window opens (first blank line).
- CLOSE_LINE, 522, vpos at which the window closes (margin before line 0).
- GRANT_TIMEOUT, 2048, max cycles one grant may be held before it is revoked.

Ports:
- clk, input, 1, pixel clock; same clock as hvsync_generator.
- reset, input, 1, synchronous, active-low; sampled on rising clk.
- hpos, input, 10, horizontal position from hvsync_generator.
- vpos, input, 10, vertical position from hvsync_generator.
- req, input, NUM_REQ, per-requester "needs update this frame".
- done, input, NUM_REQ, per-requester completion; only meaningful while granted.
- grant, output, NUM_REQ, one-hot or zero; the requester may write state while its bit is high.
- window_open, output, 1, high from the open event to the close event.
- frame_count, output, 8, frames opened since reset; wraps.
- missed_mask, output, NUM_REQ, requesters not completed in the current/last window.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; grant=0, window_open=0, frame_count=0, missed_mask=0; pending register and timeout counter cleared.
- Reset mid-grant: grant drops on the same edge, with no miss recorded.
- Open event: hpos==0 && vpos==OPEN_LINE; occurs once per frame.
- Close event: hpos==0 && vpos==CLOSE_LINE.
- Both events are decoded combinationally from the inputs and acted on at the next edge.
- IDLE: on open event go to SCAN.
  - pending<=req (req sampled only here; later req changes are ignored until the next frame).
  - window_open<=1, frame_count<=frame_count+1 (8-bit wrap 255->0), missed_mask<=0.
- SCAN: pick the lowest-index set bit of pending.
  - If found: grant<=one-hot of that index, clear its pending bit, timeout counter<=0, go to GRANT.
  - If none: go to DRAIN.
- GRANT: hold grant.
  - done of the granted index high: grant<=0, go to SCAN.
  - Timeout counter reaches GRANT_TIMEOUT-1 without done: grant<=0, set that missed_mask bit, go to SCAN.
  - done of non-granted indices is ignored.
- DRAIN: idle with the window open.
- Close event in any non-IDLE state:
  - grant<=0, window_open<=0, go to IDLE.
  - Granted-but-not-done index and all still-pending bits are OR'd into missed_mask.
  - missed_mask then holds stable until the next open event.
- Simultaneous done and close: done wins; the requester is counted complete and its missed bit is not set.
- Simultaneous timeout and close: missed bit set once, result identical.
- Latency:
  - Open event sampled at edge N: window_open=1 after N; first grant after N+1.
  - done sampled at edge M: grant low after M; next grant after M+1.
  - One dead cycle between grants (SCAN); grant is never asserted for two requesters at once.
- Open event while not IDLE cannot occur with legal parameters (OPEN_LINE<CLOSE_LINE); it is ignored.
- No requests latched: SCAN goes straight to DRAIN and grant stays 0 all window.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - SCAN searches from index (last_granted+1) mod NUM_REQ, wrapping.
  - last_granted is updated on each grant, persists across frames, and resets to NUM_REQ-1 (so the first search starts at 0).
  - Prevents low-index requesters from starving high-index ones when windows are cut short.
- Not defined: fixed priority, lowest index first; no last_granted register.

Test Plan:
- Reset, then a frame with req=4'b0000 -> window_open high from OPEN_LINE to CLOSE_LINE, grant stays 0, frame_count=1, missed_mask=0.
- req=4'b1011, each done asserted 3 cycles after its grant -> grants 0001, 0010, 1000 in order, one dead cycle between grants, missed_mask=0.
- req=4'b0011, requester 0 never asserts done, GRANT_TIMEOUT=16 -> grant[0] dropped after 16 cycles, grant[1] follows, missed_mask=4'b0001.
- req=4'b0111, requester 1 holds its grant past CLOSE_LINE with a large timeout -> grant drops at the close event, missed_mask=4'b0110, state IDLE.
- done asserted on the same cycle as the close event -> that requester not marked missed; 256 frames -> frame_count wraps to 0.
- ROUND_ROBIN_EN, req=4'b1111, window cut after 2 grants each frame -> frame1 grants 0,1; frame2 grants 2,3; frame3 grants 0,1.

Source files
------------

// File: rtl/vblank_update_scheduler.sv
// Grants game-logic updaters exclusive, one-at-a-time access to frame state during vertical blanking.
// Optional: define ROUND_ROBIN_EN for rotating search priority; default build is fixed lowest-index priority.
module vblank_update_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned OPEN_LINE     = 480,
  parameter int unsigned CLOSE_LINE    = 522,
  parameter int unsigned GRANT_TIMEOUT = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               window_open,
  output logic [7:0]         frame_count,
  output logic [NUM_REQ-1:0] missed_mask
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_GRANT,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               window_open_q, window_open_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic [NUM_REQ-1:0] missed_q, missed_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
`ifdef ROUND_ROBIN_EN
  logic [IW-1:0]      last_q, last_d;
`endif

  logic               open_ev;
  logic               close_ev;
  logic               done_hit;
  logic               tmo_hit;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  int                 cand;

  assign open_ev  = (hpos == 10'd0) && (vpos == 10'(OPEN_LINE));
  assign close_ev = (hpos == 10'd0) && (vpos == 10'(CLOSE_LINE));
  assign done_hit = |(done & grant_q);
  assign tmo_hit  = (tmo_cnt_q == TW'(GRANT_TIMEOUT - 1));

  // Next requester to serve: first pending bit found from the search start.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
`ifdef ROUND_ROBIN_EN
      cand = (int'(last_q) + 1 + i) % int'(NUM_REQ);
`else
      cand = i;
`endif
      if (!pick_found && pending_q[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pick_onehot[IW'(i)] = (pick_idx == IW'(i));
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    window_open_d = window_open_q;
    frame_count_d = frame_count_q;
    missed_d      = missed_q;
    pending_d     = pending_q;
    tmo_cnt_d     = tmo_cnt_q;
`ifdef ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (open_ev) begin
          state_d       = S_SCAN;
          pending_d     = req;
          window_open_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          missed_d      = '0;
        end
      end
      S_SCAN: begin
        if (close_ev) begin
          state_d       = S_IDLE;
          window_open_d = 1'b0;
          missed_d      = missed_q | pending_q;
          pending_d     = '0;
        end else if (pick_found) begin
          state_d   = S_GRANT;
          grant_d   = pick_onehot;
          pending_d = pending_q & ~pick_onehot;
          tmo_cnt_d = '0;
`ifdef ROUND_ROBIN_EN
          last_d    = pick_idx;
`endif
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_GRANT: begin
        // A done on the close edge still counts as completed.
        if (close_ev) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          window_open_d = 1'b0;
          missed_d      = missed_q | pending_q | (done_hit ? '0 : grant_q);
          pending_d     = '0;
        end else if (done_hit) begin
          state_d = S_SCAN;
          grant_d = '0;
        end else if (tmo_hit) begin
          state_d  = S_SCAN;
          grant_d  = '0;
          missed_d = missed_q | grant_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (close_ev) begin
          state_d       = S_IDLE;
          window_open_d = 1'b0;
          missed_d      = missed_q | pending_q;
          pending_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      window_open_q <= 1'b0;
      frame_count_q <= 8'd0;
      missed_q      <= '0;
      pending_q     <= '0;
      tmo_cnt_q     <= '0;
`ifdef ROUND_ROBIN_EN
      last_q        <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      window_open_q <= window_open_d;
      frame_count_q <= frame_count_d;
      missed_q      <= missed_d;
      pending_q     <= pending_d;
      tmo_cnt_q     <= tmo_cnt_d;
`ifdef ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign window_open = window_open_q;
  assign frame_count = frame_count_q;
  assign missed_mask = missed_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed self-checking bench for vblank_update_scheduler (NUM_REQ=4, GRANT_TIMEOUT=16).
module tb_vblank_update_scheduler;

  localparam logic [9:0] OPEN_L  = 10'd480;
  localparam logic [9:0] CLOSE_L = 10'd522;

  logic       clk;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       window_open;
  logic [7:0] frame_count;
  logic [3:0] missed_mask;

  int n_pass;
  int n_total;

  vblank_update_scheduler #(
    .NUM_REQ      (4),
    .OPEN_LINE    (480),
    .CLOSE_LINE   (522),
    .GRANT_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .window_open(window_open),
    .frame_count(frame_count),
    .missed_mask(missed_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a line-start position for exactly one edge.
  task automatic fire(input logic [9:0] line);
    hpos = 10'd0;
    vpos = line;
    step();
    hpos = 10'd5;
    vpos = 10'd100;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    hpos  = 10'd5;
    vpos  = 10'd100;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (window_open !== 1'b0) $display("FAIL reset_window: got %b want 0", window_open); else n_pass++;
    n_total++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else n_pass++;
    n_total++; if (missed_mask !== 4'b0000) $display("FAIL reset_missed: got %b want 0000", missed_mask); else n_pass++;
  endtask

  task automatic test_empty_frame();
    logic any_grant;
    logic win_drop;
    any_grant = 1'b0;
    win_drop  = 1'b0;
    req = 4'b0000;
    fire(OPEN_L);
    n_total++; if (window_open !== 1'b1) $display("FAIL empty_window_open: got %b want 1", window_open); else n_pass++;
    n_total++; if (frame_count !== 8'd1) $display("FAIL empty_frame_count: got %0d want 1", frame_count); else n_pass++;
    repeat (20) begin
      step();
      if (grant !== 4'b0000) any_grant = 1'b1;
      if (window_open !== 1'b1) win_drop = 1'b1;
    end
    n_total++; if (any_grant !== 1'b0) $display("FAIL empty_no_grant: got %b want 0", any_grant); else n_pass++;
    n_total++; if (win_drop !== 1'b0) $display("FAIL empty_window_held: got drop=%b want 0", win_drop); else n_pass++;
    fire(CLOSE_L);
    n_total++; if (window_open !== 1'b0) $display("FAIL empty_window_close: got %b want 0", window_open); else n_pass++;
    n_total++; if (missed_mask !== 4'b0000) $display("FAIL empty_missed: got %b want 0000", missed_mask); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b1000;
    do_reset();
    req = 4'b1011;
    fire(OPEN_L);
    req = 4'b0100;
    n_total++; if (grant !== 4'b0000) $display("FAIL seq_scan_idle: got %b want 0000", grant); else n_pass++;
    step();
    for (int k = 0; k < 3; k++) begin
      n_total++; if (grant !== exp_g[k]) $display("FAIL seq_grant%0d: got %b want %b", k, grant, exp_g[k]); else n_pass++;
      done = 4'b1011 & ~exp_g[k];
      step();
      done = 4'b0000;
      step();
      done = exp_g[k];
      step();
      done = 4'b0000;
      n_total++; if (grant !== 4'b0000) $display("FAIL seq_dead%0d: got %b want 0000", k, grant); else n_pass++;
      step();
    end
    n_total++; if (grant !== 4'b0000) $display("FAIL seq_drain: got %b want 0000", grant); else n_pass++;
    n_total++; if (window_open !== 1'b1) $display("FAIL seq_window: got %b want 1", window_open); else n_pass++;
    fire(CLOSE_L);
    req = 4'b0000;
    n_total++; if (missed_mask !== 4'b0000) $display("FAIL seq_missed: got %b want 0000", missed_mask); else n_pass++;
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    req = 4'b0011;
    fire(OPEN_L);
    req = 4'b0000;
    step();
    n_total++; if (grant !== 4'b0001) $display("FAIL tmo_grant0: got %b want 0001", grant); else n_pass++;
    hi = 0;
    for (int c = 0; c < 40 && grant === 4'b0001; c++) begin
      hi++;
      step();
    end
    n_total++; if (hi !== 16) $display("FAIL tmo_hold_cycles: got %0d want 16", hi); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL tmo_revoked: got %b want 0000", grant); else n_pass++;
    n_total++; if (missed_mask !== 4'b0001) $display("FAIL tmo_missed_early: got %b want 0001", missed_mask); else n_pass++;
    step();
    n_total++; if (grant !== 4'b0010) $display("FAIL tmo_grant1: got %b want 0010", grant); else n_pass++;
    done = 4'b0010;
    step();
    done = 4'b0000;
    fire(CLOSE_L);
    n_total++; if (missed_mask !== 4'b0001) $display("FAIL tmo_missed: got %b want 0001", missed_mask); else n_pass++;
  endtask

  task automatic test_close_mid_grant();
    do_reset();
    req = 4'b0111;
    fire(OPEN_L);
    req = 4'b0000;
    step();
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    n_total++; if (grant !== 4'b0010) $display("FAIL cmg_grant1: got %b want 0010", grant); else n_pass++;
    repeat (3) step();
    fire(CLOSE_L);
    n_total++; if (grant !== 4'b0000) $display("FAIL cmg_grant_drop: got %b want 0000", grant); else n_pass++;
    n_total++; if (window_open !== 1'b0) $display("FAIL cmg_window: got %b want 0", window_open); else n_pass++;
    n_total++; if (missed_mask !== 4'b0110) $display("FAIL cmg_missed: got %b want 0110", missed_mask); else n_pass++;
    repeat (20) step();
    fire(CLOSE_L);
    n_total++; if (missed_mask !== 4'b0110) $display("FAIL cmg_missed_hold: got %b want 0110", missed_mask); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL cmg_idle_grant: got %b want 0000", grant); else n_pass++;
    fire(OPEN_L);
    n_total++; if (frame_count !== 8'd2) $display("FAIL cmg_reopen_count: got %0d want 2", frame_count); else n_pass++;
    n_total++; if (missed_mask !== 4'b0000) $display("FAIL cmg_reopen_missed: got %b want 0000", missed_mask); else n_pass++;
    fire(CLOSE_L);
  endtask

  task automatic test_done_at_close();
    do_reset();
    req = 4'b0011;
    fire(OPEN_L);
    req = 4'b0000;
    step();
    n_total++; if (grant !== 4'b0001) $display("FAIL dac_grant0: got %b want 0001", grant); else n_pass++;
    step();
    done = 4'b0001;
    fire(CLOSE_L);
    done = 4'b0000;
    n_total++; if (missed_mask !== 4'b0010) $display("FAIL dac_missed: got %b want 0010", missed_mask); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL dac_grant: got %b want 0000", grant); else n_pass++;
  endtask

  task automatic test_timeout_at_close();
    do_reset();
    req = 4'b0001;
    fire(OPEN_L);
    req = 4'b0000;
    step();
    repeat (15) step();
    n_total++; if (grant !== 4'b0001) $display("FAIL tac_still_granted: got %b want 0001", grant); else n_pass++;
    fire(CLOSE_L);
    n_total++; if (missed_mask !== 4'b0001) $display("FAIL tac_missed: got %b want 0001", missed_mask); else n_pass++;
    n_total++; if (window_open !== 1'b0) $display("FAIL tac_window: got %b want 0", window_open); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0001;
    fire(OPEN_L);
    req = 4'b0000;
    step();
    n_total++; if (grant !== 4'b0001) $display("FAIL rmg_grant: got %b want 0001", grant); else n_pass++;
    reset = 1'b0;
    step();
    n_total++; if (grant !== 4'b0000) $display("FAIL rmg_grant_drop: got %b want 0000", grant); else n_pass++;
    n_total++; if (missed_mask !== 4'b0000) $display("FAIL rmg_missed: got %b want 0000", missed_mask); else n_pass++;
    n_total++; if (frame_count !== 8'd0) $display("FAIL rmg_frame_count: got %0d want 0", frame_count); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] g1 [3];
    logic [3:0] g2 [3];
    logic [3:0] ms [3];
`ifdef ROUND_ROBIN_EN
    g1[0] = 4'b0001; g2[0] = 4'b0010; ms[0] = 4'b1100;
    g1[1] = 4'b0100; g2[1] = 4'b1000; ms[1] = 4'b0011;
    g1[2] = 4'b0001; g2[2] = 4'b0010; ms[2] = 4'b1100;
`else
    g1[0] = 4'b0001; g2[0] = 4'b0010; ms[0] = 4'b1100;
    g1[1] = 4'b0001; g2[1] = 4'b0010; ms[1] = 4'b1100;
    g1[2] = 4'b0001; g2[2] = 4'b0010; ms[2] = 4'b1100;
`endif
    do_reset();
    for (int f = 0; f < 3; f++) begin
      req = 4'b1111;
      fire(OPEN_L);
      req = 4'b0000;
      step();
      n_total++; if (grant !== g1[f]) $display("FAIL rr_f%0d_first: got %b want %b", f, grant, g1[f]); else n_pass++;
      done = g1[f];
      step();
      done = 4'b0000;
      step();
      n_total++; if (grant !== g2[f]) $display("FAIL rr_f%0d_second: got %b want %b", f, grant, g2[f]); else n_pass++;
      done = g2[f];
      step();
      done = 4'b0000;
      fire(CLOSE_L);
      n_total++; if (missed_mask !== ms[f]) $display("FAIL rr_f%0d_missed: got %b want %b", f, missed_mask, ms[f]); else n_pass++;
    end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    req = 4'b0000;
    repeat (255) begin
      fire(OPEN_L);
      step();
      fire(CLOSE_L);
    end
    n_total++; if (frame_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_count); else n_pass++;
    fire(OPEN_L);
    n_total++; if (frame_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", frame_count); else n_pass++;
    fire(CLOSE_L);
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    hpos    = 10'd5;
    vpos    = 10'd100;
    req     = 4'b0000;
    done    = 4'b0000;
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_empty_frame();
    test_sequence();
    test_timeout();
    test_close_mid_grant();
    test_done_at_close();
    test_timeout_at_close();
    test_reset_mid_grant();
    test_round_robin();
    test_frame_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
